spi_note_sender: RTL and testbench

SPI_NOTE_SENDER -- requirements
Module: spi_note_sender

---
 rtl/spi_note_sender.sv | 182 ++++++++++++++++++
 tb/tb_spi_note_sender.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_note_sender.sv
// SPI mode-0 transmitter for MIDI-style note frames: a 4-byte NOTEON or a 2-byte NOTEOFF
// per accepted command, MSB first, with a fixed sclk-low gap between bytes.
module spi_note_sender #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned BYTE_GAP = 8,
    parameter logic [7:0]  NOTEON   = 8'h90,
    parameter logic [7:0]  NOTEOFF  = 8'h80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       note_status,
    input  logic [7:0] voice_index,
    input  logic [6:0] midi_note,
    input  logic [6:0] velocity,
    output logic       SPI_sclk,
    output logic       SPI_mosi,
    output logic       SPI_cs_n,
    output logic       busy,
    output logic       tx_done
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           r_state,     w_state_nxt;
    logic [DIV_W-1:0] r_div_cnt,   w_div_cnt_nxt;
    logic [2:0]       r_bit_cnt,   w_bit_cnt_nxt;
    logic [1:0]       r_byte_cnt,  w_byte_cnt_nxt;
    logic [1:0]       r_last_byte, w_last_byte_nxt;
    logic [GAP_W-1:0] r_gap_cnt,   w_gap_cnt_nxt;
    logic [31:0]      r_shift,     w_shift_nxt;
    logic             r_sclk,      w_sclk_nxt;
    logic             r_mosi,      w_mosi_nxt;
    logic             r_cs_n,      w_cs_n_nxt;
    logic             r_tx_done,   w_tx_done_nxt;
    logic             r_cmd_ready, w_cmd_ready_nxt;
    logic             r_busy,      w_busy_nxt;
    logic [31:0]      w_frame;

    // NOTEOFF only ever sends the top two bytes; the zero tail is never shifted out.
    assign w_frame = note_status ? {NOTEON, voice_index, 1'b0, midi_note, 1'b0, velocity}
                                 : {NOTEOFF, voice_index, 16'h0000};

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt     = r_state;
        w_div_cnt_nxt   = r_div_cnt;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_last_byte_nxt = r_last_byte;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_shift_nxt     = r_shift;
        w_sclk_nxt      = r_sclk;
        w_mosi_nxt      = r_mosi;
        w_cs_n_nxt      = r_cs_n;
        w_tx_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cs_n_nxt = 1'b1;
                w_sclk_nxt = 1'b0;
                w_mosi_nxt = 1'b0;
                if (cmd_valid && r_cmd_ready) begin
                    w_state_nxt     = S_SHIFT;
                    w_shift_nxt     = w_frame;
                    w_last_byte_nxt = note_status ? 2'd3 : 2'd1;
                    w_div_cnt_nxt   = '0;
                    w_bit_cnt_nxt   = '0;
                    w_byte_cnt_nxt  = '0;
                    w_gap_cnt_nxt   = '0;
                    w_cs_n_nxt      = 1'b0;
                    w_mosi_nxt      = w_frame[31];
                end
            end
            S_SHIFT: begin
                if (r_div_cnt == DIV_LAST) begin
                    w_div_cnt_nxt = '0;
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                    end else begin
                        // Falling sclk: the only point where mosi moves, a full low phase before the next rise.
                        w_sclk_nxt  = 1'b0;
                        w_shift_nxt = {r_shift[30:0], 1'b0};
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt   = S_GAP;
                            w_bit_cnt_nxt = '0;
                            w_gap_cnt_nxt = '0;
                            w_mosi_nxt    = 1'b0;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                            w_mosi_nxt    = r_shift[30];
                        end
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_gap_cnt_nxt = '0;
                    if (r_byte_cnt == r_last_byte) begin
                        w_state_nxt   = S_DONE;
                        w_cs_n_nxt    = 1'b1;
                        w_mosi_nxt    = 1'b0;
                        w_tx_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = S_SHIFT;
                        w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                        w_div_cnt_nxt  = '0;
                        w_mosi_nxt     = r_shift[31];
                    end
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cs_n_nxt  = 1'b1;
                w_sclk_nxt  = 1'b0;
                w_mosi_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: the frame shift register is a plain register, so it is cleared with everything else.
        if (reset) begin
            r_state     <= S_IDLE;
            r_div_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_last_byte <= '0;
            r_gap_cnt   <= '0;
            r_shift     <= '0;
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_tx_done   <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div_cnt   <= w_div_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_last_byte <= w_last_byte_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_sclk      <= w_sclk_nxt;
            r_mosi      <= w_mosi_nxt;
            r_cs_n      <= w_cs_n_nxt;
            r_tx_done   <= w_tx_done_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign SPI_sclk  = r_sclk;
    assign SPI_mosi  = r_mosi;
    assign SPI_cs_n  = r_cs_n;
    assign tx_done   = r_tx_done;

endmodule

// File: tb/tb_spi_note_sender.sv
// Directed bench for spi_note_sender: an SPI receiver model rebuilds each frame and
// measures cs_n timing; results are compared with hand-computed bytes and lengths.
module tb_spi_note_sender;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned BYTE_GAP = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       note_status = 1'b0;
    logic [7:0] voice_index = 8'h00;
    logic [6:0] midi_note = 7'h00;
    logic [6:0] velocity = 7'h00;
    logic       SPI_sclk;
    logic       SPI_mosi;
    logic       SPI_cs_n;
    logic       busy;
    logic       tx_done;

    spi_note_sender #(
        .CLK_DIV (CLK_DIV),
        .BYTE_GAP(BYTE_GAP),
        .NOTEON  (8'h90),
        .NOTEOFF (8'h80)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .note_status(note_status),
        .voice_index(voice_index),
        .midi_note  (midi_note),
        .velocity   (velocity),
        .SPI_sclk   (SPI_sclk),
        .SPI_mosi   (SPI_mosi),
        .SPI_cs_n   (SPI_cs_n),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_passed++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Receiver model: samples on the falling clk edge, captures mosi on each sclk rise.
    logic        prev_sclk = 1'b0;
    logic        prev_cs_n = 1'b1;
    logic        prev_mosi = 1'b0;
    logic [7:0]  rx_sh = '0;
    logic [31:0] rx_word = '0;
    int          rx_bits = 0;
    int          rx_bytes = 0;
    int          low_cnt = 0;
    int          high_cnt = 0;
    int          high_before = 0;
    int          since_chg = 0;
    int          viol = 0;
    int          done_total = 0;
    logic [31:0] q_word[$];
    int          q_nb[$];
    int          q_low[$];
    int          q_high[$];

    always @(negedge clk) begin
        if (tx_done) done_total++;
        if (!SPI_cs_n) begin
            if (prev_cs_n) begin
                low_cnt = 0; rx_bits = 0; rx_bytes = 0; rx_word = '0;
                high_before = high_cnt;
            end
            low_cnt++;
            if (SPI_mosi != prev_mosi) begin
                if (SPI_sclk) viol++;
                since_chg = 0;
            end else begin
                since_chg++;
            end
            if (SPI_sclk && !prev_sclk) begin
                if (since_chg < int'(CLK_DIV)) viol++;
                rx_sh = {rx_sh[6:0], SPI_mosi};
                rx_bits++;
                if (rx_bits == 8) begin
                    rx_word = {rx_word[23:0], rx_sh};
                    rx_bytes++;
                    rx_bits = 0;
                end
            end
        end else begin
            if (!prev_cs_n) begin
                q_word.push_back(rx_word);
                q_nb.push_back(rx_bytes);
                q_low.push_back(low_cnt);
                q_high.push_back(high_before);
                high_cnt = 0;
            end
            high_cnt++;
            if (SPI_sclk || SPI_mosi) viol++;
        end
        prev_sclk = SPI_sclk;
        prev_cs_n = SPI_cs_n;
        prev_mosi = SPI_mosi;
    end

    task automatic send(input string tag, input logic st, input logic [7:0] v,
                        input logic [6:0] n, input logic [6:0] ve, input logic hold);
        logic ok = 1'b0;
        @(negedge clk);
        note_status = st; voice_index = v; midi_note = n; velocity = ve;
        cmd_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_accepted"}, ok, 1);
        #1;
        check({tag, "_first_cs_n"}, SPI_cs_n, 0);
        check({tag, "_first_sclk"}, SPI_sclk, 0);
        check({tag, "_first_mosi"}, SPI_mosi, 1);
        check({tag, "_busy"}, {busy, cmd_ready}, 2'b10);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_tx_done_seen"}, seen, 1);
        @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int idx, input logic [31:0] word,
                               input int nb, input int low);
        check({tag, "_captured"}, (idx >= 0 && idx < q_word.size()), 1);
        if (idx >= 0 && idx < q_word.size()) begin
            check({tag, "_bytes"}, q_word[idx], word);
            check({tag, "_nbytes"}, q_nb[idx], nb);
            check({tag, "_cs_low_cycles"}, q_low[idx], low);
        end
    endtask

    int done_base;
    int q_base;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_cs_n", SPI_cs_n, 1);
        check("rst_sclk", SPI_sclk, 0);
        check("rst_mosi", SPI_mosi, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);

        // NOTEON voice 3, note 60, velocity 100
        done_base = done_total;
        send("on", 1'b1, 8'd3, 7'd60, 7'd100, 1'b0);
        wait_done("on");
        check_frame("on", q_word.size() - 1, 32'h90033C64, 4, 288);
        check("on_done_pulses", done_total - done_base, 1);

        // NOTEOFF voice 5 with nonzero note/velocity that must not be sent
        done_base = done_total;
        send("off", 1'b0, 8'd5, 7'h55, 7'h2A, 1'b0);
        wait_done("off");
        check_frame("off", q_word.size() - 1, 32'h00008005, 2, 144);
        check("off_done_pulses", done_total - done_base, 1);

        // Bounds: voice 0xFF, note 127, velocity 0
        send("bounds", 1'b1, 8'hFF, 7'd127, 7'd0, 1'b0);
        wait_done("bounds");
        check_frame("bounds", q_word.size() - 1, 32'h90FF7F00, 4, 288);

        // Back-to-back with cmd_valid held high across both frames
        done_base = done_total;
        q_base = q_word.size();
        send("b2b_a", 1'b1, 8'h21, 7'h11, 7'h22, 1'b1);
        send("b2b_b", 1'b0, 8'h42, 7'h33, 7'h44, 1'b0);
        wait_done("b2b_b");
        check_frame("b2b_a", q_base, 32'h90211122, 4, 288);
        check_frame("b2b_b", q_base + 1, 32'h00008042, 2, 144);
        check("b2b_cs_high_gap", (q_high.size() > q_base + 1) ? q_high[q_base + 1] : -1, 2);
        check("b2b_done_pulses", done_total - done_base, 2);

        // Inputs toggled and cmd_valid pulsed mid-frame
        done_base = done_total;
        q_base = q_word.size();
        send("noise", 1'b0, 8'h12, 7'h01, 7'h02, 1'b0);
        for (int cyc = 0; cyc < 140; cyc++) begin
            @(negedge clk);
            cmd_valid = (cyc == 20 || cyc == 50 || cyc == 100);
            note_status = cyc[0];
            voice_index = 8'($urandom);
            midi_note = 7'($urandom);
            velocity = 7'($urandom);
        end
        cmd_valid = 1'b0;
        wait_done("noise");
        repeat (200) @(negedge clk);
        check_frame("noise", q_base, 32'h00008012, 2, 144);
        check("noise_frame_count", q_word.size() - q_base, 1);
        check("noise_done_pulses", done_total - done_base, 1);

        // Reset during bit 4 of byte 2, then a clean frame
        done_base = done_total;
        send("abort", 1'b1, 8'h66, 7'h55, 7'h44, 1'b0);
        repeat (170) @(negedge clk);
        reset = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        check("abort_cs_n", SPI_cs_n, 1);
        check("abort_sclk", SPI_sclk, 0);
        check("abort_mosi", SPI_mosi, 0);
        check("abort_tx_done", tx_done, 0);
        check("abort_ready", {busy, cmd_ready}, 2'b01);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("abort_done_pulses", done_total - done_base, 0);
        send("after", 1'b1, 8'h07, 7'h40, 7'h7F, 1'b0);
        wait_done("after");
        check_frame("after", q_word.size() - 1, 32'h9007407F, 4, 288);
        check("after_done_pulses", done_total - done_base, 1);

        check("spi_timing_violations", viol, 0);
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
